// File: rtl/trdb_trace_ctrl.sv
// Trace qualification sequencer: evaluates privilege/address-range filters on each
// retired instruction and walks IDLE -> ARMED -> TRACING -> FLUSH, producing the
// per-instruction qualification, window-start pulse, flush handshake and stop request.
module trdb_trace_ctrl #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned FLUSH_TIMEOUT = 16,
  parameter int unsigned CNT_W         = $clog2(FLUSH_TIMEOUT + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            trace_activated_i,
  input  logic            apply_filters_i,
  input  logic            trace_selected_priv_i,
  input  logic [1:0]      which_priv_i,
  input  logic [1:0]      priv_lvl_i,
  input  logic            trace_range_event_i,
  input  logic            trace_stop_event_i,
  input  logic [XLEN-1:0] trace_lower_addr_i,
  input  logic [XLEN-1:0] trace_higher_addr_i,
  input  logic [XLEN-1:0] iaddr_i,
  input  logic            valid_i,
  input  logic            flush_done_i,
  output logic            trace_qualified_o,
  output logic            first_qualified_o,
  output logic            flush_req_o,
  output logic            trace_req_deactivate_o,
  output logic            flush_timeout_o,
  output logic            trace_range_match_o,
  output logic            trace_priv_match_o
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StArmed   = 2'd1;
  localparam logic [1:0] StTracing = 2'd2;
  localparam logic [1:0] StFlush   = 2'd3;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(FLUSH_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stop_lock_q, stop_lock_d;
  logic             qual_q, qual_d;
  logic             first_q, first_d;
  logic             deact_q, deact_d;
  logic             timeout;

  logic range_match;
  logic priv_ok;
  logic qual;
  logic stop_hit;
  logic cnt_last;

  // Filter evaluation; an inverted range (lower > higher) can never satisfy both bounds.
  always_comb begin
    range_match = (trace_lower_addr_i <= iaddr_i) && (iaddr_i <= trace_higher_addr_i);
    priv_ok     = ~trace_selected_priv_i | (priv_lvl_i == which_priv_i);
    qual        = ~apply_filters_i | ((~trace_range_event_i | range_match) & priv_ok);
    stop_hit    = apply_filters_i & trace_stop_event_i & valid_i &
                  (iaddr_i == trace_higher_addr_i);
    cnt_last    = (cnt_q == CntLast);
  end

  // Activation state machine and next-state for the registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stop_lock_d = stop_lock_q;
    qual_d      = 1'b0;
    first_d     = 1'b0;
    deact_d     = 1'b0;
    timeout     = 1'b0;
    case (state_q)
      StIdle: begin
        if (trace_activated_i && !stop_lock_q) begin
          state_d = StArmed;
        end
        // Lock only releases once software has really dropped activation.
        if (!trace_activated_i) begin
          stop_lock_d = 1'b0;
        end
      end
      StArmed: begin
        if (!trace_activated_i) begin
          state_d = StIdle;
        end else if (valid_i && qual) begin
          state_d = StTracing;
          qual_d  = 1'b1;
          first_d = 1'b1;
        end
      end
      StTracing: begin
        if (!trace_activated_i) begin
          state_d = StFlush;
          qual_d  = valid_i & qual;
        end else if (stop_hit) begin
          // The stop instruction itself is still traced.
          state_d     = StFlush;
          qual_d      = 1'b1;
          deact_d     = 1'b1;
          stop_lock_d = 1'b1;
        end else if (valid_i && !qual) begin
          state_d = StFlush;
        end else begin
          qual_d = valid_i;
        end
      end
      StFlush: begin
        if (flush_done_i || cnt_last) begin
          timeout = ~flush_done_i;
          cnt_d   = '0;
          state_d = (trace_activated_i && !stop_lock_q) ? StArmed : StIdle;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs, asynchronously cleared.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      stop_lock_q <= 1'b0;
      qual_q      <= 1'b0;
      first_q     <= 1'b0;
      deact_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stop_lock_q <= stop_lock_d;
      qual_q      <= qual_d;
      first_q     <= first_d;
      deact_q     <= deact_d;
    end
  end

  // Output drive; the combinational matches are forced low while reset is held.
  always_comb begin
    trace_qualified_o      = qual_q;
    first_qualified_o      = first_q;
    trace_req_deactivate_o = deact_q;
    flush_req_o            = (state_q == StFlush);
    flush_timeout_o        = timeout;
    trace_range_match_o    = range_match & ~rst_i;
    trace_priv_match_o     = priv_ok & ~rst_i;
  end

endmodule

// File: tb/tb_trdb_trace_ctrl.sv
// Directed self-checking bench for trdb_trace_ctrl.
module tb_trdb_trace_ctrl;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            act, apply, sel_priv, range_ev, stop_ev, valid, flush_done;
  logic [1:0]      which_priv, priv_lvl;
  logic [XLEN-1:0] lower, higher, iaddr;
  logic            q, f, freq, deact, tmo, rm, pm;
  logic [4:0]      seq;

  int tests = 0;
  int fails = 0;

  assign seq = {q, f, freq, deact, tmo};

  always #5 clk = ~clk;

  trdb_trace_ctrl #(.XLEN(XLEN), .FLUSH_TIMEOUT(16)) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .trace_activated_i      (act),
    .apply_filters_i        (apply),
    .trace_selected_priv_i  (sel_priv),
    .which_priv_i           (which_priv),
    .priv_lvl_i             (priv_lvl),
    .trace_range_event_i    (range_ev),
    .trace_stop_event_i     (stop_ev),
    .trace_lower_addr_i     (lower),
    .trace_higher_addr_i    (higher),
    .iaddr_i                (iaddr),
    .valid_i                (valid),
    .flush_done_i           (flush_done),
    .trace_qualified_o      (q),
    .first_qualified_o      (f),
    .flush_req_o            (freq),
    .trace_req_deactivate_o (deact),
    .flush_timeout_o        (tmo),
    .trace_range_match_o    (rm),
    .trace_priv_match_o     (pm)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Return to IDLE with activation low and any stop lock released.
  task automatic shutdown();
    act = 1'b0; valid = 1'b0; flush_done = 1'b0;
    tick();
    flush_done = 1'b1;
    tick();
    flush_done = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [6:0] exp;
    rst = 1'b1;
    lower = '0; higher = 32'hFFFF_FFFF; iaddr = 32'h5; sel_priv = 1'b0;
    #1;
    exp = 7'b0;
    if ({seq, rm, pm} !== exp) begin
      fails++; $display("FAIL reset_outputs: got %b exp %b", {seq, rm, pm}, exp);
    end
    tests++;
    tick(); tick();
    if ({seq, rm, pm} !== exp) begin
      fails++; $display("FAIL reset_held: got %b exp %b", {seq, rm, pm}, exp);
    end
    tests++;
    rst = 1'b0;
    #1;
    exp = 7'b0000011;
    if ({seq, rm, pm} !== exp) begin
      fails++; $display("FAIL reset_release_match: got %b exp %b", {seq, rm, pm}, exp);
    end
    tests++;
    iaddr = '0; higher = '0;
  endtask

  task automatic test_filters_off();
    apply = 1'b0; act = 1'b1; valid = 1'b0;
    tick();
    valid = 1'b1; iaddr = 32'h100;
    tick();
    if (seq !== 5'b11000) begin fails++; $display("FAIL fo_first: got %b exp %b", seq, 5'b11000); end
    tests++;
    tick();
    if (seq !== 5'b10000) begin fails++; $display("FAIL fo_q2: got %b exp %b", seq, 5'b10000); end
    tests++;
    tick();
    if (seq !== 5'b10000) begin fails++; $display("FAIL fo_q3: got %b exp %b", seq, 5'b10000); end
    tests++;
    valid = 1'b0;
    tick();
    if (seq !== 5'b00000) begin fails++; $display("FAIL fo_gap: got %b exp %b", seq, 5'b00000); end
    tests++;
    shutdown();
  endtask

  task automatic test_range();
    apply = 1'b1; range_ev = 1'b1; sel_priv = 1'b0; stop_ev = 1'b0;
    lower = 32'h1000; higher = 32'h1FFF; act = 1'b1;
    tick();
    valid = 1'b1; iaddr = 32'h0FFC;
    #1;
    if (rm !== 1'b0) begin fails++; $display("FAIL rng_below_match: got %b exp 0", rm); end
    tests++;
    tick();
    if (seq !== 5'b00000) begin fails++; $display("FAIL rng_below: got %b exp %b", seq, 5'b00000); end
    tests++;
    iaddr = 32'h1000;
    #1;
    if (rm !== 1'b1) begin fails++; $display("FAIL rng_lower_match: got %b exp 1", rm); end
    tests++;
    tick();
    if (seq !== 5'b11000) begin fails++; $display("FAIL rng_lower: got %b exp %b", seq, 5'b11000); end
    tests++;
    iaddr = 32'h1FFC;
    tick();
    if (seq !== 5'b10000) begin fails++; $display("FAIL rng_top: got %b exp %b", seq, 5'b10000); end
    tests++;
    iaddr = 32'h2000;
    #1;
    if (rm !== 1'b0) begin fails++; $display("FAIL rng_above_match: got %b exp 0", rm); end
    tests++;
    tick();
    if (seq !== 5'b00100) begin fails++; $display("FAIL rng_flush: got %b exp %b", seq, 5'b00100); end
    tests++;
    valid = 1'b0;
    tick(); tick();
    flush_done = 1'b1;
    #1;
    if (seq !== 5'b00100) begin fails++; $display("FAIL rng_flush3: got %b exp %b", seq, 5'b00100); end
    tests++;
    tick();
    flush_done = 1'b0;
    if (seq !== 5'b00000) begin fails++; $display("FAIL rng_flush_exit: got %b exp %b", seq, 5'b00000); end
    tests++;
    valid = 1'b1; iaddr = 32'h1000;
    tick();
    if (seq !== 5'b11000) begin fails++; $display("FAIL rng_rearmed: got %b exp %b", seq, 5'b11000); end
    tests++;
    shutdown();
  endtask

  task automatic test_priv();
    apply = 1'b1; range_ev = 1'b0; sel_priv = 1'b1; which_priv = 2'd3; stop_ev = 1'b0;
    lower = 32'h20; higher = 32'h10; act = 1'b1;
    tick();
    valid = 1'b1; priv_lvl = 2'd0; iaddr = 32'h10;
    #1;
    if ({rm, pm} !== 2'b00) begin fails++; $display("FAIL priv_u_match: got %b exp 00", {rm, pm}); end
    tests++;
    tick();
    if (seq !== 5'b00000) begin fails++; $display("FAIL priv_u: got %b exp %b", seq, 5'b00000); end
    tests++;
    priv_lvl = 2'd3; iaddr = 32'h20;
    #1;
    if ({rm, pm} !== 2'b01) begin fails++; $display("FAIL priv_m_match: got %b exp 01", {rm, pm}); end
    tests++;
    tick();
    if (seq !== 5'b11000) begin fails++; $display("FAIL priv_m_first: got %b exp %b", seq, 5'b11000); end
    tests++;
    iaddr = 32'h15;
    #1;
    if ({rm, pm} !== 2'b01) begin fails++; $display("FAIL priv_inv_range: got %b exp 01", {rm, pm}); end
    tests++;
    tick();
    if (seq !== 5'b10000) begin fails++; $display("FAIL priv_m_q: got %b exp %b", seq, 5'b10000); end
    tests++;
    priv_lvl = 2'd1;
    tick();
    if (seq !== 5'b00100) begin fails++; $display("FAIL priv_drop: got %b exp %b", seq, 5'b00100); end
    tests++;
    shutdown();
    sel_priv = 1'b0; priv_lvl = 2'd0;
  endtask

  task automatic test_stop();
    apply = 1'b1; range_ev = 1'b1; sel_priv = 1'b0; stop_ev = 1'b1;
    lower = 32'h1000; higher = 32'h1FFC; act = 1'b1;
    tick();
    valid = 1'b1; iaddr = 32'h1000;
    tick();
    if (seq !== 5'b11000) begin fails++; $display("FAIL stop_first: got %b exp %b", seq, 5'b11000); end
    tests++;
    iaddr = 32'h1FFC;
    tick();
    if (seq !== 5'b10110) begin fails++; $display("FAIL stop_hit: got %b exp %b", seq, 5'b10110); end
    tests++;
    valid = 1'b0;
    tick();
    if (seq !== 5'b00100) begin fails++; $display("FAIL stop_pulse_end: got %b exp %b", seq, 5'b00100); end
    tests++;
    flush_done = 1'b1;
    tick();
    flush_done = 1'b0;
    if (seq !== 5'b00000) begin fails++; $display("FAIL stop_flush_exit: got %b exp %b", seq, 5'b00000); end
    tests++;
    valid = 1'b1; iaddr = 32'h1000;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (seq !== 5'b00000) begin
        fails++; $display("FAIL stop_locked[%0d]: got %b exp %b", i, seq, 5'b00000);
      end
      tests++;
    end
    act = 1'b0; valid = 1'b0;
    tick();
    act = 1'b1;
    tick();
    valid = 1'b1;
    tick();
    if (seq !== 5'b11000) begin fails++; $display("FAIL stop_rearm: got %b exp %b", seq, 5'b11000); end
    tests++;
    shutdown();
    stop_ev = 1'b0; range_ev = 1'b0;
  endtask

  task automatic test_timeout();
    logic [1:0] exp;
    apply = 1'b0; act = 1'b1;
    tick();
    valid = 1'b1; iaddr = 32'h100;
    tick();
    act = 1'b0; valid = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      #1;
      exp = {1'b1, (i == 15)};
      if ({freq, tmo} !== exp) begin
        fails++; $display("FAIL to_cycle[%0d]: got %b exp %b", i, {freq, tmo}, exp);
      end
      tests++;
      tick();
    end
    if (seq !== 5'b00000) begin fails++; $display("FAIL to_exit: got %b exp %b", seq, 5'b00000); end
    tests++;
    act = 1'b1;
    tick();
    valid = 1'b1;
    tick();
    act = 1'b0; valid = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      flush_done = (i == 15);
      #1;
      exp = 2'b10;
      if ({freq, tmo} !== exp) begin
        fails++; $display("FAIL to_done_cycle[%0d]: got %b exp %b", i, {freq, tmo}, exp);
      end
      tests++;
      tick();
    end
    flush_done = 1'b0;
    if (seq !== 5'b00000) begin fails++; $display("FAIL to_done_exit: got %b exp %b", seq, 5'b00000); end
    tests++;
    shutdown();
  endtask

  task automatic test_async_reset();
    apply = 1'b0; act = 1'b1;
    tick();
    valid = 1'b1; iaddr = 32'h100;
    tick();
    if (seq !== 5'b11000) begin fails++; $display("FAIL ar_tracing: got %b exp %b", seq, 5'b11000); end
    tests++;
    #2 rst = 1'b1;
    #1;
    if (seq !== 5'b00000) begin fails++; $display("FAIL ar_mid_tracing: got %b exp %b", seq, 5'b00000); end
    tests++;
    tick();
    rst = 1'b0; valid = 1'b0;
    tick();
    valid = 1'b1;
    tick();
    if (seq !== 5'b11000) begin fails++; $display("FAIL ar_after_release: got %b exp %b", seq, 5'b11000); end
    tests++;
    apply = 1'b1; stop_ev = 1'b1; range_ev = 1'b0; higher = 32'h200; iaddr = 32'h200;
    tick();
    if (seq !== 5'b10110) begin fails++; $display("FAIL ar_stop_hit: got %b exp %b", seq, 5'b10110); end
    tests++;
    valid = 1'b0;
    tick();
    if (seq !== 5'b00100) begin fails++; $display("FAIL ar_in_flush: got %b exp %b", seq, 5'b00100); end
    tests++;
    #2 rst = 1'b1;
    #1;
    if (seq !== 5'b00000) begin fails++; $display("FAIL ar_mid_flush: got %b exp %b", seq, 5'b00000); end
    tests++;
    tick();
    rst = 1'b0;
    tick();
    valid = 1'b1; iaddr = 32'h100;
    tick();
    if (seq !== 5'b11000) begin fails++; $display("FAIL ar_lock_cleared: got %b exp %b", seq, 5'b11000); end
    tests++;
    shutdown();
  endtask

  initial begin
    rst = 1'b1; act = 1'b0; apply = 1'b0; sel_priv = 1'b0; range_ev = 1'b0; stop_ev = 1'b0;
    valid = 1'b0; flush_done = 1'b0; which_priv = 2'd0; priv_lvl = 2'd0;
    lower = '0; higher = '0; iaddr = '0;
    test_reset();
    test_filters_off();
    test_range();
    test_priv();
    test_stop();
    test_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/trdb_trace_ctrl.md
Name: trdb_trace_ctrl

Overview:
- Sequencing controller for trace qualification in the trace encoder. Sits between the control registers and the packet emitter.
- Evaluates the privilege and address-range filters on each retired instruction and runs an activation state machine: IDLE, ARMED, TRACING, FLUSH.
- Outputs a registered per-instruction qualification, a first-qualified pulse, a flush handshake toward the packet emitter, and a deactivation request back to the control register on a stop event.

Parameters:
- XLEN, 32, instruction address width.
- FLUSH_TIMEOUT, 16, maximum cycles spent in FLUSH waiting for flush_done_i; must be >= 1.
- CNT_W, $clog2(FLUSH_TIMEOUT+1), width of the flush timeout counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- trace_activated_i  in  1  tracing enabled by register.
- apply_filters_i  in  1  1 = apply priv/range filters; 0 = every valid instruction qualifies.
- trace_selected_priv_i  in  1  enable privilege filter.
- which_priv_i  in  2  privilege level to trace.
- priv_lvl_i  in  2  current privilege level.
- trace_range_event_i  in  1  enable address-range filter.
- trace_stop_event_i  in  1  enable stop-on-higher-address.
- trace_lower_addr_i  in  XLEN  range lower bound, inclusive.
- trace_higher_addr_i  in  XLEN  range upper bound, inclusive.
- iaddr_i  in  XLEN  retired instruction address.
- valid_i  in  1  retired instruction valid this cycle.
- flush_done_i  in  1  packet emitter finished final packet.
- trace_qualified_o  out  1  registered: previous-cycle instruction is traced.
- first_qualified_o  out  1  1-cycle pulse with the first traced instruction of a window (drives sync packet).
- flush_req_o  out  1  level, high throughout FLUSH.
- trace_req_deactivate_o  out  1  1-cycle pulse, clears activation register.
- flush_timeout_o  out  1  1-cycle pulse when FLUSH exits by timeout.
- trace_range_match_o  out  1  combinational range match.
- trace_priv_match_o  out  1  combinational privilege match.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, counter=0, stop_lock=0. All outputs 0.
- Range match:
  - range_match = (lower <= iaddr) & (iaddr <= higher), unsigned compare.
  - lower > higher never matches.
  - trace_range_match_o = range_match.
- Priv match: priv_ok = ~trace_selected_priv_i | (priv_lvl_i == which_priv_i). trace_priv_match_o = priv_ok.
- qual = ~apply_filters_i | ((~trace_range_event_i | range_match) & priv_ok).
- stop_hit = apply_filters_i & trace_stop_event_i & valid_i & (iaddr_i == trace_higher_addr_i).
- IDLE:
  - If trace_activated_i & ~stop_lock, go to ARMED.
  - If ~trace_activated_i, clear stop_lock.
- ARMED:
  - If ~trace_activated_i, go to IDLE. This has priority.
  - Else if valid_i & qual, go to TRACING. Next cycle trace_qualified_o=1 and first_qualified_o=1.
- TRACING:
  - trace_qualified_o(t+1) = valid_i & qual at t. Latency is exactly 1 cycle.
  - Priority order:
    1. ~trace_activated_i: go to FLUSH.
    2. stop_hit: the stop instruction itself is qualified. Pulse trace_req_deactivate_o next cycle, set stop_lock, go to FLUSH.
    3. valid_i & ~qual: go to FLUSH; not qualified.
  - valid_i=0 keeps TRACING with trace_qualified_o=0.
- FLUSH:
  - flush_req_o=1. Counter increments each cycle from 0.
  - Exit on flush_done_i, or when counter == FLUSH_TIMEOUT-1 without flush_done_i (then pulse flush_timeout_o).
  - flush_done_i on the timeout cycle: normal exit, no timeout pulse.
  - Exit target: ARMED if trace_activated_i & ~stop_lock, else IDLE. Counter cleared on exit.
  - trace_qualified_o=0 in FLUSH. Instructions arriving during FLUSH are dropped.
- stop_lock prevents re-arming until the register has actually dropped trace_activated_i.
- flush_done_i is ignored outside FLUSH. valid_i is ignored in IDLE.
- ARMED, TRACING, FLUSH reachable only via trace_activated_i=1. Deassertion is the sole software abort.

Test Plan:
- Filters off: activate, valid_i=1 at iaddr 0x100 for 3 cycles -> first_qualified_o=1 on cycle 1 only; trace_qualified_o=1 for 3 cycles, each 1 cycle after its valid_i.
- Range filter 0x1000..0x1FFF: iaddr 0x0FFC, 0x1000, 0x1FFC, 0x2000 -> qualified 0,1,1. At 0x2000: FLUSH, flush_req_o=1; flush_done_i after 3 cycles -> ARMED.
- Priv filter which_priv=3: priv_lvl 0 then 3 -> no qualification at 0; entry to TRACING and first_qualified_o pulse at 3. Range disabled, lower=0x20 > higher=0x10 -> range_match_o=0 for every iaddr.
- Stop event, higher=0x1FFC: hit at 0x1FFC -> qualified, trace_req_deactivate_o single pulse, FLUSH. After flush_done_i, IDLE. No re-arm while trace_activated_i stays 1. Drop then raise activation -> ARMED.
- Timeout FLUSH_TIMEOUT=16, flush_done_i never asserted -> exactly 16 FLUSH cycles, flush_timeout_o pulse on the last one. Repeat with flush_done_i on cycle 16 -> no timeout pulse.
- Async reset asserted mid-TRACING and mid-FLUSH -> all outputs 0 immediately; IDLE after release; stop_lock cleared.
